// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master: state encoding,
// SPI mode constants and a constant-foldable clog2.
package spi_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LEAD  = 3'd2;
    localparam logic [2:0] S_TRAIL = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_SETUP = S_SETUP,
        ST_LEAD  = S_LEAD,
        ST_TRAIL = S_TRAIL,
        ST_HOLD  = S_HOLD
    } spi_state_t;

    // Mode constants packed as {CPOL, CPHA}.
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Half-period down-counter: restart loads HALF_PERIOD-1, phase_done is high
// on the last system clock of each SCLK half-period.
module spi_phase_timer
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_restart,
    output logic o_phase_done
);

    localparam int CNT_W = clog2(HALF_PERIOD) + 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count <= RELOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_phase_done = (r_count == '0);

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master with configurable width, divider, mode and chip
// selects. One word per request; MSB first on MOSI, first MISO bit lands in the MSB.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int   DATA_WIDTH  = 8,
    parameter int   NUM_CS      = 1,
    parameter int   HALF_PERIOD = 1,
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b0,
    parameter int   CS_SEL_W    = (clog2(NUM_CS) > 1) ? clog2(NUM_CS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic [CS_SEL_W-1:0]   i_cs_sel,
    output logic                  o_rx_valid,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_sclk,
    output logic                  o_mosi,
    input  logic                  i_miso,
    output logic [NUM_CS-1:0]     o_cs_n,
    output logic [2:0]            o_state
);

    localparam int BIT_W = clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(DATA_WIDTH - 1);

    // Handshake: a request is taken on any clock edge where i_tx_valid and
    // o_tx_ready are both high; data and select are sampled only then.
    // o_tx_ready stays low until the cycle o_rx_valid pulses.

    spi_state_t            r_state;
    logic                  r_tx_ready;
    logic                  r_rx_valid;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_sclk;
    logic                  r_mosi;
    logic [NUM_CS-1:0]     r_cs_n;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [BIT_W-1:0]      r_bit_cnt;

    logic w_accept;
    logic w_phase_done;
    logic w_restart;

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_SEL_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(sel) == i) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    assign w_accept  = i_tx_valid & r_tx_ready;
    assign w_restart = w_accept | ((r_state != ST_IDLE) & w_phase_done);

    spi_phase_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_phase_timer (
        .clock        (clock),
        .reset        (reset),
        .i_restart    (w_restart),
        .o_phase_done (w_phase_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tx_ready <= 1'b1;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_sclk     <= CPOL;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_SETUP;
                        r_tx_ready <= 1'b0;
                        r_cs_n     <= cs_decode(i_cs_sel);
                        r_bit_cnt  <= LAST_IDX;
                        r_rx_shift <= '0;
                        // CPHA=0 presents the MSB before the first edge.
                        if (CPHA) begin
                            r_mosi     <= 1'b0;
                            r_tx_shift <= i_tx_data;
                        end else begin
                            r_mosi     <= i_tx_data[DATA_WIDTH-1];
                            r_tx_shift <= i_tx_data << 1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (w_phase_done) begin
                        r_state <= ST_LEAD;
                        r_sclk  <= ~CPOL;
                        if (CPHA) begin
                            r_mosi     <= r_tx_shift[DATA_WIDTH-1];
                            r_tx_shift <= r_tx_shift << 1;
                        end
                    end
                end
                ST_LEAD: begin
                    if (w_phase_done) begin
                        r_state <= ST_TRAIL;
                        r_sclk  <= CPOL;
                        if (!CPHA) begin
                            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], i_miso};
                            if (r_bit_cnt != '0) begin
                                r_mosi     <= r_tx_shift[DATA_WIDTH-1];
                                r_tx_shift <= r_tx_shift << 1;
                            end
                        end
                    end
                end
                ST_TRAIL: begin
                    if (w_phase_done) begin
                        if (CPHA) begin
                            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], i_miso};
                        end
                        if (r_bit_cnt == '0) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - BIT_W'(1);
                            r_state   <= ST_LEAD;
                            r_sclk    <= ~CPOL;
                            if (CPHA) begin
                                r_mosi     <= r_tx_shift[DATA_WIDTH-1];
                                r_tx_shift <= r_tx_shift << 1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_phase_done) begin
                        r_state    <= ST_IDLE;
                        r_tx_ready <= 1'b1;
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= r_rx_shift;
                        r_cs_n     <= '1;
                        r_mosi     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_ready = r_tx_ready;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_data;
    assign o_sclk     = r_sclk;
    assign o_mosi     = r_mosi;
    assign o_cs_n     = r_cs_n;
    assign o_state    = r_state;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: three instances (mode 0 / 4 CS loopback,
// mode 3 divided clock, 12-bit mode 1) checked against a transfer-timeline model.
module tb_spi_master_param;
    import spi_pkg::*;

    localparam int          CW   [3] = '{8, 8, 12};
    localparam int          CH   [3] = '{1, 4, 2};
    localparam int          CP   [3] = '{0, 1, 0};
    localparam int          CA   [3] = '{0, 1, 1};
    localparam int          NCS  [3] = '{4, 1, 1};
    localparam int          CSW  [3] = '{3, 1, 1};
    localparam int          LOOP [3] = '{1, 0, 0};
    localparam logic [15:0] SLV  [3] = '{16'h0000, 16'h00C3, 16'h00F0};

    logic clock;
    logic rst [3];
    logic tv [3];
    logic [15:0] td [3];
    logic [2:0] csel [3];
    logic s_miso [3];

    logic a_ready, a_rxv, a_sclk, a_mosi;
    logic [7:0] a_rx;
    logic [3:0] a_cs;
    logic [2:0] a_st;
    logic b_ready, b_rxv, b_sclk, b_mosi, b_cs;
    logic [7:0] b_rx;
    logic [2:0] b_st;
    logic c_ready, c_rxv, c_sclk, c_mosi, c_cs;
    logic [11:0] c_rx;
    logic [2:0] c_st;

    logic d_ready [3], d_rxv [3], d_sclk [3], d_mosi [3];
    logic [15:0] d_rx [3];
    logic [3:0] d_cs [3];
    logic [2:0] d_st [3];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    spi_master_param #(
        .DATA_WIDTH (8), .NUM_CS (4), .HALF_PERIOD (1),
        .CPOL (SPI_MODE0[1]), .CPHA (SPI_MODE0[0]), .CS_SEL_W (3)
    ) u_a (
        .clock (clock), .reset (rst[0]), .i_tx_valid (tv[0]), .o_tx_ready (a_ready),
        .i_tx_data (td[0][7:0]), .i_cs_sel (csel[0]), .o_rx_valid (a_rxv),
        .o_rx_data (a_rx), .o_sclk (a_sclk), .o_mosi (a_mosi), .i_miso (a_mosi),
        .o_cs_n (a_cs), .o_state (a_st)
    );

    spi_master_param #(
        .DATA_WIDTH (8), .NUM_CS (1), .HALF_PERIOD (4),
        .CPOL (SPI_MODE3[1]), .CPHA (SPI_MODE3[0])
    ) u_b (
        .clock (clock), .reset (rst[1]), .i_tx_valid (tv[1]), .o_tx_ready (b_ready),
        .i_tx_data (td[1][7:0]), .i_cs_sel (csel[1][0]), .o_rx_valid (b_rxv),
        .o_rx_data (b_rx), .o_sclk (b_sclk), .o_mosi (b_mosi), .i_miso (s_miso[1]),
        .o_cs_n (b_cs), .o_state (b_st)
    );

    spi_master_param #(
        .DATA_WIDTH (12), .NUM_CS (1), .HALF_PERIOD (2),
        .CPOL (SPI_MODE1[1]), .CPHA (SPI_MODE1[0])
    ) u_c (
        .clock (clock), .reset (rst[2]), .i_tx_valid (tv[2]), .o_tx_ready (c_ready),
        .i_tx_data (td[2][11:0]), .i_cs_sel (csel[2][0]), .o_rx_valid (c_rxv),
        .o_rx_data (c_rx), .o_sclk (c_sclk), .o_mosi (c_mosi), .i_miso (s_miso[2]),
        .o_cs_n (c_cs), .o_state (c_st)
    );

    assign d_ready[0] = a_ready;  assign d_ready[1] = b_ready;  assign d_ready[2] = c_ready;
    assign d_rxv[0]   = a_rxv;    assign d_rxv[1]   = b_rxv;    assign d_rxv[2]   = c_rxv;
    assign d_sclk[0]  = a_sclk;   assign d_sclk[1]  = b_sclk;   assign d_sclk[2]  = c_sclk;
    assign d_mosi[0]  = a_mosi;   assign d_mosi[1]  = b_mosi;   assign d_mosi[2]  = c_mosi;
    assign d_rx[0]    = {8'h00, a_rx};
    assign d_rx[1]    = {8'h00, b_rx};
    assign d_rx[2]    = {4'h0, c_rx};
    assign d_cs[0]    = a_cs;
    assign d_cs[1]    = {3'b111, b_cs};
    assign d_cs[2]    = {3'b111, c_cs};
    assign d_st[0]    = a_st;     assign d_st[1]    = b_st;     assign d_st[2]    = c_st;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Model: each transfer is a timeline of (2W+2)*H cycles after the accept edge.
    bit          m_on [3];
    bit          m_busy [3];
    int          m_t [3];
    logic [15:0] m_data [3];
    int          m_cs [3];
    logic        m_rxv [3];
    logic [15:0] m_rx [3];
    logic [15:0] m_word [3];

    always @(posedge clock) begin
        cyc++;
        for (int c = 0; c < 3; c++) begin
            if (rst[c]) begin
                m_on[c]   = 1'b1;
                m_busy[c] = 1'b0;
                m_rxv[c]  = 1'b0;
                m_rx[c]   = 16'h0;
            end else begin
                m_rxv[c] = 1'b0;
                if (m_busy[c]) begin
                    m_t[c]++;
                    if (m_t[c] == (2 * CW[c] + 2) * CH[c]) begin
                        m_busy[c] = 1'b0;
                        m_rxv[c]  = 1'b1;
                        m_rx[c]   = m_word[c];
                    end
                end else if (tv[c]) begin
                    m_busy[c] = 1'b1;
                    m_t[c]    = 0;
                    m_data[c] = td[c] & 16'((1 << CW[c]) - 1);
                    m_cs[c]   = int'(csel[c]) & ((1 << CSW[c]) - 1);
                    m_word[c] = (LOOP[c] != 0) ? m_data[c] : SLV[c];
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int c = 0; c < 3; c++) begin
            if (m_on[c]) begin
                int p, idx, w;
                logic e_ready, e_sclk, e_mosi;
                logic [3:0] e_cs;
                w = CW[c];
                e_ready = !m_busy[c];
                e_sclk  = (CP[c] != 0);
                e_mosi  = 1'b0;
                e_cs    = 4'hF;
                if (m_busy[c]) begin
                    p = m_t[c] / CH[c];
                    if (p >= 1 && p <= 2 * w && (p % 2) == 1) e_sclk = (CP[c] == 0);
                    if (CA[c] == 0) idx = (p == 0) ? 0 : p / 2;
                    else            idx = (p == 0) ? 0 : (p - 1) / 2;
                    if (idx > w - 1) idx = w - 1;
                    e_mosi = (CA[c] != 0 && p == 0) ? 1'b0 : m_data[c][w-1-idx];
                    if (m_cs[c] < NCS[c]) e_cs[m_cs[c]] = 1'b0;
                end
                n_cmp++;
                if (d_ready[c] !== e_ready || d_rxv[c] !== m_rxv[c] || d_rx[c] !== m_rx[c] ||
                    d_sclk[c] !== e_sclk || d_mosi[c] !== e_mosi || d_cs[c] !== e_cs ||
                    ((d_st[c] == S_IDLE) != !m_busy[c])) begin
                    n_fail++;
                    $display("FAIL cycle ch%0d cyc=%0d: got rdy=%b rxv=%b rx=%h sclk=%b mosi=%b cs=%b st=%0d, want rdy=%b rxv=%b rx=%h sclk=%b mosi=%b cs=%b idle=%b",
                             c, cyc, d_ready[c], d_rxv[c], d_rx[c], d_sclk[c], d_mosi[c], d_cs[c], d_st[c],
                             e_ready, m_rxv[c], m_rx[c], e_sclk, e_mosi, e_cs, !m_busy[c]);
                end
            end
        end
    end

    // Slave for CPHA=1 channels: drives the next pattern bit on each leading edge.
    int   scnt [3];
    logic s_prev [3];
    always @(negedge clock) begin
        for (int c = 1; c < 3; c++) begin
            logic [15:0] pat;
            pat = SLV[c];
            if (d_cs[c][0]) begin
                scnt[c]   = 0;
                s_miso[c] = 1'b0;
            end else if (d_sclk[c] != s_prev[c] && d_sclk[c] == (CP[c] == 0)) begin
                s_miso[c] = pat[CW[c]-1-scnt[c]];
                scnt[c]++;
            end
            s_prev[c] = d_sclk[c];
        end
    end

    // Observation counters feeding the literal checks.
    int          low_cnt [3], lead_cnt [3], lead_cyc [3], lead_per [3], rx_cnt [3];
    logic [15:0] last_rx [3];
    logic [3:0]  cs_and [3];
    logic        m_prev [3];
    logic        mosi_q[$];
    int          rxcyc_q[$];
    logic [15:0] rx_q[$];
    logic [3:0]  csrx_q[$];

    always @(negedge clock) begin
        for (int c = 0; c < 3; c++) begin
            if (d_ready[c] == 1'b0) low_cnt[c]++;
            cs_and[c] = cs_and[c] & d_cs[c];
            if (d_sclk[c] != m_prev[c] && d_sclk[c] == (CP[c] == 0)) begin
                if (lead_cnt[c] > 0) lead_per[c] = cyc - lead_cyc[c];
                lead_cyc[c] = cyc;
                lead_cnt[c]++;
                if (c == 0) mosi_q.push_back(d_mosi[0]);
            end
            if (d_rxv[c]) begin
                rx_cnt[c]++;
                last_rx[c] = d_rx[c];
                if (c == 0) begin
                    rxcyc_q.push_back(cyc);
                    rx_q.push_back(d_rx[0]);
                    csrx_q.push_back(d_cs[0]);
                end
            end
            m_prev[c] = d_sclk[c];
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic clr(input int c);
        low_cnt[c] = 0; lead_cnt[c] = 0; lead_per[c] = 0; rx_cnt[c] = 0;
        cs_and[c] = 4'hF;
        if (c == 0) begin
            mosi_q.delete(); rxcyc_q.delete(); rx_q.delete(); csrx_q.delete();
        end
    endtask

    task automatic send(input int c, input logic [15:0] data, input logic [2:0] sel, input bit keep);
        int n;
        @(negedge clock);
        tv[c] = 1'b1; td[c] = data; csel[c] = sel;
        n = 0;
        while (!d_ready[c] && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) chk("accept_timeout", n, 0);
        @(negedge clock);
        if (!keep) begin
            tv[c] = 1'b0;
            td[c] = 16'($urandom);
            csel[c] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic wait_done(input int c, input int n);
        int k;
        k = 0;
        while (rx_cnt[c] < n && k < 2000) begin
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        chk("rx_pulses", rx_cnt[c], n);
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin
            rst[c] = 1'b1; tv[c] = 1'b0; td[c] = 16'h0; csel[c] = 3'd0;
            s_miso[c] = 1'b0; s_prev[c] = 1'b0; scnt[c] = 0; m_prev[c] = 1'b0;
            m_on[c] = 1'b0; m_busy[c] = 1'b0; clr(c);
        end
        repeat (3) @(negedge clock);
        for (int c = 0; c < 3; c++) rst[c] = 1'b0;
        chk("reset_sclk_mode3", int'(b_sclk), 1);
        chk("reset_cs_a", int'(a_cs), 4'hF);
        chk("reset_ready_a", int'(a_ready), 1);
        chk("reset_rx_c", int'(c_rx), 0);

        // Mode 0 loopback of A5.
        clr(0);
        send(0, 16'h00A5, 3'd0, 1'b0);
        wait_done(0, 1);
        chk("a5_rises", mosi_q.size(), 8);
        begin
            logic [7:0] exp_bits;
            logic [7:0] got_bits;
            exp_bits = 8'b1010_0101;
            got_bits = '0;
            for (int i = 0; i < 8 && i < mosi_q.size(); i++) got_bits[7-i] = mosi_q[i];
            chk("a5_mosi_at_rise", int'(got_bits), int'(exp_bits));
        end
        chk("a5_rx", int'(last_rx[0]), 'hA5);
        chk("a5_ready_low", low_cnt[0], 18);

        // Chip select decode, in range and out of range.
        clr(0);
        send(0, 16'h0096, 3'd2, 1'b0);
        wait_done(0, 1);
        chk("cs2_lines", int'(cs_and[0]), 4'b1011);
        chk("cs2_rx", int'(last_rx[0]), 'h96);
        clr(0);
        send(0, 16'h0069, 3'd5, 1'b0);
        wait_done(0, 1);
        chk("cs5_lines", int'(cs_and[0]), 4'b1111);
        chk("cs5_rx", int'(last_rx[0]), 'h69);

        // Back-to-back with tx_valid held high.
        clr(0);
        send(0, 16'h003C, 3'd1, 1'b1);
        send(0, 16'h00C5, 3'd1, 1'b0);
        wait_done(0, 2);
        chk("b2b_word0", int'(rx_q.size() > 0 ? rx_q[0] : 16'hFFFF), 'h3C);
        chk("b2b_word1", int'(rx_q.size() > 1 ? rx_q[1] : 16'hFFFF), 'hC5);
        chk("b2b_pulse_gap", rxcyc_q.size() > 1 ? rxcyc_q[1] - rxcyc_q[0] : 0, 19);
        chk("b2b_cs_high_at_rxv", int'(csrx_q.size() > 0 ? csrx_q[0] : 4'h0), 4'hF);

        // Reset during bit 4, then a clean transfer.
        clr(0);
        send(0, 16'h00FF, 3'd1, 1'b0);
        repeat (9) @(negedge clock);
        rst[0] = 1'b1;
        @(negedge clock);
        rst[0] = 1'b0;
        chk("abort_cs", int'(a_cs), 4'hF);
        chk("abort_sclk", int'(a_sclk), 0);
        chk("abort_ready", int'(a_ready), 1);
        chk("abort_rxv", int'(a_rxv), 0);
        repeat (2) @(negedge clock);
        chk("abort_no_pulse", rx_cnt[0], 0);
        clr(0);
        send(0, 16'h005A, 3'd3, 1'b0);
        wait_done(0, 1);
        chk("after_abort_rx", int'(last_rx[0]), 'h5A);

        // Mode 3, divided clock, slave returns C3.
        clr(1);
        send(1, 16'h003C, 3'd0, 1'b0);
        wait_done(1, 1);
        chk("m3_rx", int'(last_rx[1]), 'hC3);
        chk("m3_edges", lead_cnt[1], 8);
        chk("m3_period", lead_per[1], 8);
        chk("m3_ready_low", low_cnt[1], 72);

        // 12-bit mode 1, slave returns 0F0.
        clr(2);
        send(2, 16'h0F0F, 3'd0, 1'b0);
        wait_done(2, 1);
        chk("w12_rx", int'(last_rx[2]), 'h0F0);
        chk("w12_pulses", lead_cnt[2], 12);
        chk("w12_ready_low", low_cnt[2], 52);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised, full-duplex SPI master. Successor to the team's fixed 8-bit, mode-0, transmit-only SPI transmitter.
- Adds configurable word width, clock divider, CPOL/CPHA mode, multiple chip selects, MISO capture, and a valid/ready request handshake.
- Sits between board control logic (pot/DAC/ADC controllers) and Pmod SPI pins.

Parameters:
- DATA_WIDTH, 8: bits per transfer, MSB first; legal range ≥ 2.
- NUM_CS, 1: number of active-low chip-select lines.
- HALF_PERIOD, 1: system clocks per SCLK half-period; legal range ≥ 1.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- CS_SEL_W, max(1, clog2(NUM_CS)): derived width of cs_sel.

Ports:
- clock, in, 1: system clock; all logic on posedge.
- reset, in, 1: reset, synchronous, active-high; clock clock.
- tx_valid, in, 1: transfer request.
- tx_ready, out, 1: idle, can accept a request.
- tx_data, in, DATA_WIDTH: word to send; captured on accept.
- cs_sel, in, CS_SEL_W: target slave index; captured on accept.
- rx_valid, out, 1: one-cycle pulse, rx_data valid.
- rx_data, out, DATA_WIDTH: word received on MISO; holds until next rx_valid.
- sclk, out, 1: SPI clock.
- mosi, out, 1: serial data out.
- miso, in, 1: serial data in (board-level synchronous; no synchroniser inside).
- cs_n, out, NUM_CS: active-low chip selects.

Behaviour:
- All outputs registered.
- Reset values: tx_ready=1, rx_valid=0, rx_data=0, sclk=CPOL, mosi=0, cs_n=all ones, state IDLE, counters 0.
- Reset mid-transfer: abort. The next cycle shows reset values; no rx_valid pulse.
- Accept occurs when tx_valid & tx_ready on a clock edge. Latch tx_data into the shift register and cs_sel into cs_reg. tx_ready goes 0 on the next cycle.
- States:
  - IDLE: tx_ready=1, sclk=CPOL, cs_n all 1, mosi=0. On accept, go to SETUP.
  - SETUP: HALF_PERIOD cycles. cs_n[cs_reg]=0, sclk=CPOL. If CPHA=0, mosi=MSB. If CPHA=1, mosi=0. Then go to LEAD.
  - LEAD: HALF_PERIOD cycles, sclk=~CPOL. If CPHA=1, mosi is updated to the current bit on entry. If CPHA=0, MISO is captured on the last cycle of LEAD. Then go to TRAIL.
  - TRAIL: HALF_PERIOD cycles, sclk=CPOL. If CPHA=1, MISO is captured on the last cycle of TRAIL. If CPHA=0 and bits remain, mosi is updated to the next bit on entry. Decrement bit counter. If it was the last bit, go to HOLD; otherwise go to LEAD.
  - HOLD: HALF_PERIOD cycles. sclk=CPOL, cs_n[cs_reg]=0, mosi holds its last value. Then go to IDLE with rx_valid=1 for one cycle, rx_data=received word, tx_ready=1.
- Captured bits shift in LSB-side. The first captured bit ends at rx_data[DATA_WIDTH-1].
- tx_ready is low for exactly (2*DATA_WIDTH+2)*HALF_PERIOD cycles per transfer.
- Back-to-back transfers: tx_valid held high is accepted in the cycle rx_valid pulses. CS deasserts for at least one cycle between words.
- tx_valid while busy: ignored. tx_data and cs_sel changes during a transfer: no effect.
- cs_sel ≥ NUM_CS: transfer still runs and rx_valid still pulses, but no cs_n line is asserted.
- Divider counter width: clog2(HALF_PERIOD)+1. The bit counter wraps only via reload on accept.

Decomposition:
- Package spi_pkg holds:
  - State encoding: IDLE/SETUP/LEAD/TRAIL/HOLD as localparams, 3 bits.
  - Mode constants SPI_MODE0..3 mapping to CPOL/CPHA pairs.
  - A clog2 helper function.
- One sub-module, spi_phase_timer: a HALF_PERIOD down-counter with restart input and a phase_done tick output, instantiated once.

Test Plan:
- DATA_WIDTH=8, HALF_PERIOD=1, mode 0, tx_data=8'hA5, MISO loopback from mosi -> 8 rising sclk edges; mosi at each rise = 1,0,1,0,0,1,0,1; rx_data=8'hA5; tx_ready low exactly 18 cycles.
- Mode 3, HALF_PERIOD=4, tx_data=8'h3C, slave model drives 8'hC3 on falling edges -> sclk idles 1; period 8 clocks; rx_data=8'hC3; rx_valid single-cycle.
- NUM_CS=4, cs_sel=2, then cs_sel=5 -> only cs_n[2] low during the first transfer; cs_n stays 4'b1111 during the second, which still completes with rx_valid.
- tx_valid held high with two different words -> second accept in the rx_valid cycle; cs_n high for ≥1 cycle between words; both rx_data words correct.
- Reset asserted at bit 4 of a transfer -> next cycle: cs_n all 1, sclk=CPOL, tx_ready=1, no rx_valid; a subsequent 8'h5A transfer completes correctly.
- DATA_WIDTH=12, mode 1, tx_data=12'hF0F -> 12 sclk pulses; rx_data matches slave pattern 12'h0F0; tx_ready low (2*12+2)*HALF_PERIOD cycles.
